// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command/response datapath: widths, edge codes,
// serializer state encoding and a constant-foldable clog2.
package spi_pkg;

    localparam int OPCODEW   = 4;
    localparam int ADDRW     = 7;
    localparam int DATAW_DEF = OPCODEW + 2 * ADDRW;

    // Edge codes over the {previous, current} synchronized history.
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } spi_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin plus rise/fall detection
// on the synchronized history; RST_VAL sets the pin's idle level.
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] w_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign w_hist = {r_prev, r_sync};
    assign o_rise = (w_hist == EDGE_RISE);
    assign o_fall = (w_hist == EDGE_FALL);

endmodule

// File: rtl/spi_resp_serializer.sv
// SPI mode-0 response transmitter: buffers one word from the core and shifts it
// out MSB-first on MISO. Define SPI_TX_PARITY_EN to append an even-parity bit.
module spi_resp_serializer
    import spi_pkg::*;
#(
    parameter int               DATAW     = DATAW_DEF,
    parameter logic [DATAW-1:0] IDLE_WORD = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_clk,
    input  logic             cs_n,
    output logic             miso,
    input  logic [DATAW-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             done,
    output logic             abort
);

`ifdef SPI_TX_PARITY_EN
    localparam int FRAMEW = DATAW + 1;
`else
    localparam int FRAMEW = DATAW;
`endif
    localparam int              CNTW     = clog2(FRAMEW + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FRAMEW);

    logic w_spi_rise, w_spi_fall, w_cs_rise, w_cs_fall;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(spi_clk),
        .o_rise (w_spi_rise),
        .o_fall (w_spi_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_state_t        r_state, w_state_next;
    logic [CNTW-1:0]   r_cnt, w_cnt_next;
    logic [FRAMEW-1:0] r_shift, w_shift_next;
    logic [DATAW-1:0]  r_word, w_word_next;
    logic [DATAW-1:0]  r_hold, w_hold_next;
    logic              r_hold_valid, w_hold_valid_next;
    logic              r_is_real, w_is_real_next;
    logic              r_ready, r_done, w_done_next, r_abort, w_abort_next;
    logic              w_accept, w_consume, w_restore;
    logic [DATAW-1:0]  w_load_word;
    logic [FRAMEW-1:0] w_load_frame;

    assign w_accept    = valid_in && r_ready;
    assign w_load_word = r_hold_valid ? r_hold : IDLE_WORD;
`ifdef SPI_TX_PARITY_EN
    assign w_load_frame = {w_load_word, ^w_load_word};
`else
    assign w_load_frame = w_load_word;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_shift_next      = r_shift;
        w_word_next       = r_word;
        w_is_real_next    = r_is_real;
        w_hold_next       = r_hold;
        w_hold_valid_next = r_hold_valid;
        w_done_next       = 1'b0;
        w_abort_next      = 1'b0;
        w_consume         = 1'b0;
        w_restore         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next   = SHIFT;
                    w_cnt_next     = '0;
                    w_shift_next   = w_load_frame;
                    w_word_next    = w_load_word;
                    w_is_real_next = r_hold_valid;
                    w_consume      = r_hold_valid;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_shift_next = '0;
                    w_abort_next = 1'b1;
                    w_restore    = r_is_real;
                end else if (w_spi_rise) begin
                    w_cnt_next = r_cnt + CNTW'(1);
                    if (r_cnt + CNTW'(1) == CNT_LAST) begin
                        w_state_next = TAIL;
                        w_done_next  = r_is_real;
                    end
                end else if (w_spi_fall && (r_cnt < CNT_LAST)) begin
                    w_shift_next = {r_shift[FRAMEW-2:0], 1'b0};
                end
            end
            TAIL: begin
                // MISO parks on the last bit until the master releases CS.
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_shift_next = '0;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // A fresh word from the core beats restoring an aborted one.
        if (w_accept) begin
            w_hold_next       = data_in;
            w_hold_valid_next = 1'b1;
        end else if (w_restore && !r_hold_valid) begin
            w_hold_next       = r_word;
            w_hold_valid_next = 1'b1;
        end else if (w_consume) begin
            w_hold_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_is_real    <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_shift      <= w_shift_next;
            r_word       <= w_word_next;
            r_is_real    <= w_is_real_next;
            r_hold       <= w_hold_next;
            r_hold_valid <= w_hold_valid_next;
            r_ready      <= ~w_hold_valid_next;
            r_done       <= w_done_next;
            r_abort      <= w_abort_next;
        end
    end

    assign miso      = r_shift[FRAMEW-1];
    assign ready_out = r_ready;
    assign done      = r_done;
    assign abort     = r_abort;

endmodule

// File: tb/tb_spi_resp_serializer.sv
// Self-checking bench for spi_resp_serializer: a SPI master model clocks frames
// while a queue of expected words is compared against what MISO delivers.
module tb_spi_resp_serializer;

    localparam int DATAW = 18;
`ifdef SPI_TX_PARITY_EN
    localparam int FW = DATAW + 1;
`else
    localparam int FW = DATAW;
`endif
    localparam logic [DATAW-1:0] IDLE_W = 18'h0;

    logic             clk;
    logic             rst_n;
    logic             spi_clk;
    logic             cs_n;
    logic             miso;
    logic [DATAW-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             done;
    logic             abort;

    int total = 0;
    int bad   = 0;
    int done_seen  = 0;
    int abort_seen = 0;
    logic [DATAW-1:0] exp_q[$];

    spi_resp_serializer #(.DATAW(DATAW), .IDLE_WORD(IDLE_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_clk  (spi_clk),
        .cs_n     (cs_n),
        .miso     (miso),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .done     (done),
        .abort    (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)  done_seen  <= done_seen + 1;
        if (abort) abort_seen <= abort_seen + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input logic [DATAW-1:0] w);
`ifdef SPI_TX_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic push_word(input logic [DATAW-1:0] w, input logic acc);
        @(negedge clk);
        check_val("ready_before_push", 32'(ready_out), 32'(acc));
        data_in  = w;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = DATAW'($urandom);
        if (acc) exp_q.push_back(w);
    endtask

    // Master: CS low, nclk mode-0 clocks sampling MISO just before each rise.
    task automatic spi_frame(input int nclk, output logic [FW-1:0] bits);
        bits = '0;
        cs_n = 1'b0;
        #200;
        for (int i = 0; i < nclk; i++) begin
            bits = {bits[FW-2:0], miso};
            spi_clk = 1'b1;
            #50;
            spi_clk = 1'b0;
            #50;
        end
        #100;
        cs_n = 1'b1;
        #200;
    endtask

    task automatic check_frame(input string tag);
        logic [FW-1:0] bits;
        logic [FW-1:0] exp;
        int d0, exp_done;
        d0 = done_seen;
        spi_frame(FW, bits);
        if (exp_q.size() > 0) begin
            exp      = frame_of(exp_q.pop_front());
            exp_done = 1;
        end else begin
            exp      = frame_of(IDLE_W);
            exp_done = 0;
        end
        check_val({tag, "_bits"}, 32'(bits), 32'(exp));
        check_val({tag, "_done"}, 32'(done_seen - d0), 32'(exp_done));
    endtask

    initial begin
        logic [FW-1:0] bits;
        int d0, a0;
        rst_n = 1'b0; cs_n = 1'b1; spi_clk = 1'b0;
        valid_in = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_miso",  32'(miso),      32'd0);
        check_val("rst_ready", 32'(ready_out), 32'd1);
        check_val("rst_done",  32'(done),      32'd0);
        check_val("rst_abort", 32'(abort),     32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single word, full frame
        push_word(18'h2A5C3, 1'b1);
        check_frame("t1");
        check_val("t1_ready_after", 32'(ready_out), 32'd1);

        // Push during a frame; third push refused while hold is full
        push_word(18'h00001, 1'b1);
        fork
            check_frame("t2a");
            begin
                #700;
                push_word(18'h3FFFF, 1'b1);
                push_word(18'h12345, 1'b0);
            end
        join
        @(negedge clk);
        check_val("t2_ready_held", 32'(ready_out), 32'd0);
        check_frame("t2b");
        check_val("t2_ready_after", 32'(ready_out), 32'd1);

        // Frame with nothing buffered
        check_frame("t3_idle");
        check_val("t3_ready", 32'(ready_out), 32'd1);

        // Abort after 7 clocks, then retransmit
        push_word(18'h2A5C3, 1'b1);
        d0 = done_seen; a0 = abort_seen;
        spi_frame(7, bits);
        check_val("t4_abort", 32'(abort_seen - a0), 32'd1);
        check_val("t4_done",  32'(done_seen - d0),  32'd0);
        check_val("t4_ready_restored", 32'(ready_out), 32'd0);
        check_frame("t4_retx");

        // Reset in the middle of a frame
        push_word(18'h2A5C3, 1'b1);
        d0 = done_seen; a0 = abort_seen;
        @(negedge clk);
        cs_n = 1'b0;
        #200;
        for (int i = 0; i < 9; i++) begin
            spi_clk = 1'b1; #50;
            spi_clk = 1'b0; #50;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t5_miso",  32'(miso),      32'd0);
        check_val("t5_ready", 32'(ready_out), 32'd1);
        check_val("t5_done",  32'(done_seen - d0),  32'd0);
        check_val("t5_abort", 32'(abort_seen - a0), 32'd0);
        cs_n = 1'b1;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #100;
        @(negedge clk);
        check_frame("t5_idle");

        // Low-weight word (odd parity weight when the parity bit is enabled)
        push_word(18'h00007, 1'b1);
        check_frame("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
